fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 114 +++++++++++
 tb/tb_fetch_queue.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential word-aligned fetches to a
// fixed 1-cycle-latency instruction memory and buffers {pc, instr} pairs in
// a DEPTH-entry circular queue for the decode stage.
//
// Ports:
//   clk, rst         - clock; synchronous active-high reset
//   imem_req/addr    - instruction-memory read request and word address
//   imem_data        - instruction returned for last cycle's request
//   redirect/_target - flush the queue and restart fetch at a new PC
//   halt_in          - stop issuing new requests (queue keeps draining)
//   deq_*            - head entry handshake and contents (pc, pc + 4, instr)
//   count            - number of valid entries in the queue
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_data,
  input  logic                     redirect,
  input  logic [31:0]              redirect_target,
  input  logic                     halt_in,
  input  logic                     deq_ready,
  output logic                     deq_valid,
  output logic [31:0]              deq_pc,
  output logic [31:0]              deq_pc4,
  output logic [31:0]              deq_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   fpc_q, fpc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   req_pc_q, req_pc_d;

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic [CW:0]   occupancy;
  logic          push;
  logic          pop;

  assign imem_addr = {fpc_q[31:2], 2'b00};
  assign count     = count_q;
  assign deq_valid = (count_q != '0);
  assign deq_pc    = pc_mem[head_q];
  assign deq_instr = instr_mem[head_q];
  assign deq_pc4   = deq_pc + 32'd4;

  always_comb begin
    // An in-flight request has a reserved slot, so it counts as occupied.
    occupancy = {1'b0, count_q} + (CW + 1)'(inflight_q);
    imem_req  = !rst && !redirect && !halt_in && (occupancy < (CW + 1)'(DEPTH));
    push      = inflight_q && !redirect;
    pop       = deq_valid && deq_ready && !redirect;

    fpc_d      = fpc_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = imem_req;
    req_pc_d   = imem_addr;

    if (redirect) begin
      fpc_d   = {redirect_target[31:2], 2'b00};
      count_d = '0;
      // Keep tail aligned with head so refill starts at the current head slot.
      tail_d  = head_q;
    end else begin
      if (imem_req) fpc_d = fpc_q + 32'd4;
      if (push) tail_d = tail_q + PW'(1);
      if (pop) head_d = head_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q      <= RESET_PC;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
      req_pc_q   <= '0;
    end else begin
      fpc_q      <= fpc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= inflight_d;
      req_pc_q   <= req_pc_d;
    end
  end

  // Entry storage needs no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem[tail_q]    <= req_pc_q;
      instr_mem[tail_q] <= imem_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        halt_in;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_pc;
  logic [31:0] deq_pc4;
  logic [31:0] deq_instr;
  logic [2:0]  count;

  int n_cmp;
  int n_bad;

  fetch_queue #(
    .DEPTH   (4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .halt_in        (halt_in),
    .deq_ready      (deq_ready),
    .deq_valid      (deq_valid),
    .deq_pc         (deq_pc),
    .deq_pc4        (deq_pc4),
    .deq_instr      (deq_instr),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns addr ^ A5A5_0000 one cycle after the address is presented.
  logic [31:0] mem_addr_q;
  always @(posedge clk) mem_addr_q <= imem_addr;
  assign imem_data = mem_addr_q ^ 32'hA5A5_0000;

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Leaves the bench in the first cycle after reset release.
  task automatic do_reset(input logic ready);
    rst = 1'b1; redirect = 1'b0; halt_in = 1'b0; deq_ready = ready;
    redirect_target = 32'h0;
    next_cycle();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; halt_in = 1'b0; deq_ready = 1'b1;
    redirect_target = 32'h0;
    next_cycle();
    next_cycle();
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++;
      $display("FAIL reset_req: got %b want 0", imem_req); end
    n_cmp++; if (deq_valid !== 1'b0) begin n_bad++;
      $display("FAIL reset_valid: got %b want 0", deq_valid); end
    n_cmp++; if (count !== 3'd0) begin n_bad++;
      $display("FAIL reset_count: got %0d want 0", count); end
    rst = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_bad++;
      $display("FAIL first_req: got req=%b addr=%h want req=1 addr=00000000",
               imem_req, imem_addr); end
  endtask

  task automatic test_cold_start();
    next_cycle();
    n_cmp++; if (deq_valid !== 1'b0 || imem_addr !== 32'h4) begin n_bad++;
      $display("FAIL cold_c1: got valid=%b addr=%h want valid=0 addr=00000004",
               deq_valid, imem_addr); end
    next_cycle();
    n_cmp++; if (deq_valid !== 1'b1 || deq_pc !== 32'h0 || deq_pc4 !== 32'h4 ||
                 deq_instr !== 32'hA5A5_0000) begin n_bad++;
      $display("FAIL cold_first: got valid=%b pc=%h pc4=%h instr=%h want 1/0/4/a5a50000",
               deq_valid, deq_pc, deq_pc4, deq_instr); end
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      n_cmp++;
      if (deq_valid !== 1'b1 || deq_pc !== 32'(4 * k) || deq_pc4 !== 32'(4 * k + 4) ||
          deq_instr !== (32'(4 * k) ^ 32'hA5A5_0000) || count !== 3'd1) begin
        n_bad++;
        $display("FAIL cold_stream%0d: got valid=%b pc=%h pc4=%h instr=%h count=%0d want pc=%h count=1",
                 k, deq_valid, deq_pc, deq_pc4, deq_instr, count, 32'(4 * k));
      end
    end
  endtask

  task automatic test_fill_drain();
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) next_cycle();
    n_cmp++; if (count !== 3'd4 || imem_req !== 1'b0 || deq_pc !== 32'h0) begin n_bad++;
      $display("FAIL fill_full: got count=%0d req=%b pc=%h want 4/0/00000000",
               count, imem_req, deq_pc); end
    next_cycle();
    next_cycle();
    n_cmp++; if (count !== 3'd4 || deq_pc !== 32'h0 || deq_instr !== 32'hA5A5_0000) begin
      n_bad++;
      $display("FAIL fill_hold: got count=%0d pc=%h instr=%h want 4/00000000/a5a50000",
               count, deq_pc, deq_instr); end
    deq_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      n_cmp++;
      if (deq_valid !== 1'b1 || deq_pc !== 32'(4 * k)) begin
        n_bad++;
        $display("FAIL drain%0d: got valid=%b pc=%h want 1/%h", k, deq_valid, deq_pc,
                 32'(4 * k));
      end
      if (k == 1) begin
        n_cmp++; if (count !== 3'd3 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
          n_bad++;
          $display("FAIL full_pop: got count=%0d req=%b addr=%h want 3/1/00000010",
                   count, imem_req, imem_addr); end
      end
    end
  endtask

  task automatic test_full_push_pop();
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) next_cycle();
    n_cmp++; if (count !== 3'd3 || imem_req !== 1'b0) begin n_bad++;
      $display("FAIL pp_pre: got count=%0d req=%b want 3/0", count, imem_req); end
    deq_ready = 1'b1;
    next_cycle();
    deq_ready = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd3 || deq_pc !== 32'h4 || imem_req !== 1'b1 ||
                 imem_addr !== 32'h10) begin n_bad++;
      $display("FAIL push_pop: got count=%0d pc=%h req=%b addr=%h want 3/00000004/1/00000010",
               count, deq_pc, imem_req, imem_addr); end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) next_cycle();
    redirect = 1'b1; redirect_target = 32'h0000_0103; deq_ready = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++;
      $display("FAIL redir_req: got %b want 0", imem_req); end
    next_cycle();
    redirect = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd0 || deq_valid !== 1'b0 || imem_addr !== 32'h100 ||
                 imem_req !== 1'b1) begin n_bad++;
      $display("FAIL redir_flush: got count=%0d valid=%b addr=%h req=%b want 0/0/00000100/1",
               count, deq_valid, imem_addr, imem_req); end
    next_cycle();
    n_cmp++; if (count !== 3'd0 || deq_valid !== 1'b0) begin n_bad++;
      $display("FAIL redir_stale: got count=%0d valid=%b want 0/0", count, deq_valid); end
    next_cycle();
    n_cmp++; if (deq_valid !== 1'b1 || deq_pc !== 32'h100 || deq_instr !== 32'hA5A5_0100) begin
      n_bad++;
      $display("FAIL redir_first: got valid=%b pc=%h instr=%h want 1/00000100/a5a50100",
               deq_valid, deq_pc, deq_instr); end
  endtask

  task automatic test_halt();
    do_reset(1'b1);
    next_cycle();
    halt_in = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++;
      $display("FAIL halt_req: got %b want 0", imem_req); end
    next_cycle();
    n_cmp++; if (deq_valid !== 1'b1 || deq_pc !== 32'h0 || imem_req !== 1'b0) begin n_bad++;
      $display("FAIL halt_enq: got valid=%b pc=%h req=%b want 1/00000000/0",
               deq_valid, deq_pc, imem_req); end
    next_cycle();
    n_cmp++; if (deq_valid !== 1'b0 || count !== 3'd0) begin n_bad++;
      $display("FAIL halt_drain: got valid=%b count=%0d want 0/0", deq_valid, count); end
    redirect = 1'b1; redirect_target = 32'h0000_0203;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++;
      $display("FAIL halt_redir_req: got %b want 0", imem_req); end
    next_cycle();
    redirect = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h200 || count !== 3'd0) begin n_bad++;
      $display("FAIL halt_redir: got req=%b addr=%h count=%0d want 0/00000200/0",
               imem_req, imem_addr, count); end
    halt_in = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_bad++;
      $display("FAIL halt_release: got req=%b addr=%h want 1/00000200", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) next_cycle();
    n_cmp++; if (count !== 3'd2) begin n_bad++;
      $display("FAIL mid_pre: got count=%0d want 2", count); end
    rst = 1'b1; redirect = 1'b1; redirect_target = 32'h0000_0303;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++;
      $display("FAIL mid_rst_req: got %b want 0", imem_req); end
    next_cycle();
    rst = 1'b0; redirect = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd0 || deq_valid !== 1'b0 || imem_addr !== 32'h0 ||
                 imem_req !== 1'b1) begin n_bad++;
      $display("FAIL mid_rst: got count=%0d valid=%b addr=%h req=%b want 0/0/00000000/1",
               count, deq_valid, imem_addr, imem_req); end
    next_cycle();
    n_cmp++; if (count !== 3'd0) begin n_bad++;
      $display("FAIL mid_inflight: got count=%0d want 0", count); end
    next_cycle();
    n_cmp++; if (deq_valid !== 1'b1 || deq_pc !== 32'h0) begin n_bad++;
      $display("FAIL mid_restart: got valid=%b pc=%h want 1/00000000", deq_valid, deq_pc); end
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFF;
    next_cycle();
    redirect = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_bad++;
      $display("FAIL wrap_req: got req=%b addr=%h want 1/fffffffc", imem_req, imem_addr); end
    next_cycle();
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++;
      $display("FAIL wrap_addr: got %h want 00000000", imem_addr); end
    next_cycle();
    n_cmp++; if (deq_pc !== 32'hFFFF_FFFC || deq_pc4 !== 32'h0 ||
                 deq_instr !== 32'h5A5A_FFFC) begin n_bad++;
      $display("FAIL wrap_deq: got pc=%h pc4=%h instr=%h want fffffffc/00000000/5a5afffc",
               deq_pc, deq_pc4, deq_instr); end
    next_cycle();
    n_cmp++; if (deq_valid !== 1'b1 || deq_pc !== 32'h0) begin n_bad++;
      $display("FAIL wrap_next: got valid=%b pc=%h want 1/00000000", deq_valid, deq_pc); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; redirect = 1'b0; halt_in = 1'b0; deq_ready = 1'b0;
    redirect_target = 32'h0;
    test_reset();
    test_cold_start();
    test_fill_drain();
    test_full_push_pop();
    test_redirect();
    test_halt();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
